// File: rtl/bandpass_inverse.sv
`default_nettype none
// ============================================================================
// Module   : bandpass_inverse
// Brief    : Inverts y[n] = x[n-1] - x[n-3] via z[n] = y[n] + z[n-2], with a
//            2-entry output FIFO and an accepted-sample counter.
// Revision : 1.0 - initial release
// ============================================================================
module bandpass_inverse #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      sample_cnt
);

  localparam logic [1:0] c_DEPTH = 2'd2;

  logic [WIDTH-1:0] r_h1;
  logic [WIDTH-1:0] r_h2;
  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_occ;
  logic [15:0]      r_cnt;

  logic             w_accept;
  logic             w_pop;
  logic [WIDTH-1:0] w_z;
  logic [1:0]       w_occ_next;

  // Readiness depends on occupancy alone so upstream never sees a path from out_ready.
  assign in_ready   = (r_occ < c_DEPTH);
  assign out_valid  = (r_occ != 2'd0);
  assign w_accept   = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  assign w_z        = in_data + r_h2;
  assign out_data   = r_mem[r_rd_ptr];
  assign sample_cnt = r_cnt;

  always_comb begin
    w_occ_next = r_occ;
    case ({w_accept, w_pop})
      2'b10:   w_occ_next = r_occ + 2'd1;
      2'b01:   w_occ_next = r_occ - 2'd1;
      default: w_occ_next = r_occ;
    endcase
  end

  // Recurrence history and sample counter advance only on an accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h1  <= '0;
      r_h2  <= '0;
      r_cnt <= 16'd0;
    end else if (clear) begin
      r_h1  <= '0;
      r_h2  <= '0;
      r_cnt <= 16'd0;
    end else if (w_accept) begin
      r_h2  <= r_h1;
      r_h1  <= w_z;
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Storage is zeroed on restart so out_data reads 0 while the FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else if (clear) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= w_z;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= w_occ_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bandpass_inverse.sv
`default_nettype none
// ============================================================================
// Module   : tb_bandpass_inverse
// Brief    : Self-checking bench for bandpass_inverse against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bandpass_inverse;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sample_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: reconstructed samples waiting downstream, plus the two last outputs.
  logic [15:0] m_q [$];
  logic [15:0] m_z1, m_z2, m_cnt;

  bandpass_inverse #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_z1 = '0; m_z2 = '0; m_cnt = '0;
  endtask

  task automatic tick();
    bit acc, pop;
    logic [15:0] z;
    acc = in_valid && (m_q.size() < 2);
    pop = out_ready && (m_q.size() > 0);
    z = in_data + m_z2;
    @(posedge clk);
    if (clear) begin
      model_reset();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(z);
        m_z2 = m_z1; m_z1 = z; m_cnt = m_cnt + 16'd1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; clear = 0; rst = 1;
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (sample_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", sample_cnt); end
  endtask

  task automatic test_impulse();
    logic [15:0] y [6] = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    logic [15:0] e [6] = '{16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0};
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_data = y[i];
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== e[i]) begin
        n_fail++; $display("FAIL impulse[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, e[i]);
      end
    end
    in_valid = 0;
    tick();
    n_checks++; if (sample_cnt !== 16'd6) begin n_fail++; $display("FAIL impulse_cnt got %0d want 6", sample_cnt); end
  endtask

  task automatic test_roundtrip();
    int x [6] = '{3, -7, 100, 32767, -32768, 12};
    int xm1, xm3;
    logic [15:0] exp_v;
    do_reset();
    out_ready = 1;
    for (int n = 0; n < 6; n++) begin
      xm1 = (n >= 1) ? x[n-1] : 0;
      xm3 = (n >= 3) ? x[n-3] : 0;
      in_data = 16'(xm1 - xm3); in_valid = 1;
      tick();
      exp_v = 16'(xm1);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_v) begin
        n_fail++; $display("FAIL roundtrip[%0d] got v=%b d=%h want d=%h", n, out_valid, out_data, exp_v);
      end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_wrap();
    logic [15:0] y [3] = '{16'h7FFF, 16'h0000, 16'h7FFF};
    logic [15:0] e [3] = '{16'h7FFF, 16'h0000, 16'hFFFE};
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = y[i];
      tick();
      n_checks++;
      if (out_data !== e[i]) begin
        n_fail++; $display("FAIL wrap[%0d] got %h want %h", i, out_data, e[i]);
      end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] got [$];
    logic [15:0] e [3] = '{16'd5, 16'd5, 16'd10};
    do_reset();
    out_ready = 0; in_valid = 1; in_data = 16'd5;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    tick();
    n_checks++;
    if (sample_cnt !== 16'd2 || out_valid !== 1'b1 || out_data !== 16'd5) begin
      n_fail++; $display("FAIL bp_hold got cnt=%0d v=%b d=%h want cnt=2 v=1 d=0005", sample_cnt, out_valid, out_data);
    end
    out_ready = 1;
    for (int i = 0; i < 12 && got.size() < 3; i++) begin
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
      if (sample_cnt == 16'd3) in_valid = 0;
    end
    n_checks++;
    if (got.size() != 3) begin
      n_fail++; $display("FAIL bp_count got %0d transfers want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got[i] !== e[i]) begin n_fail++; $display("FAIL bp_order[%0d] got %h want %h", i, got[i], e[i]); end
      end
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got v=%b want 0", out_valid); end
  endtask

  task automatic test_clear_rst();
    do_reset();
    out_ready = 1; in_valid = 1; in_data = 16'd4;
    tick(); tick();
    clear = 1; in_data = 16'd9;
    tick();
    clear = 0;
    n_checks++;
    if (sample_cnt !== 16'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL clear_state got cnt=%0d v=%b want cnt=0 v=0", sample_cnt, out_valid);
    end
    in_data = 16'd2;
    tick();
    in_valid = 0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd2 || sample_cnt !== 16'd1) begin
      n_fail++; $display("FAIL clear_next got v=%b d=%h cnt=%0d want v=1 d=0002 cnt=1", out_valid, out_data, sample_cnt);
    end
    tick();
    // Same sequence, but restart through an asynchronous pulse between edges.
    out_ready = 0; in_valid = 1; in_data = 16'd4;
    tick(); tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre got v=%b want 1", out_valid); end
    #2 rst = 1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b1 || sample_cnt !== 16'h0) begin
      n_fail++; $display("FAIL rst_async got v=%b d=%h rdy=%b cnt=%0d want v=0 d=0000 rdy=1 cnt=0",
                         out_valid, out_data, in_ready, sample_cnt);
    end
    #1 rst = 0;
    model_reset();
    out_ready = 1; in_valid = 1; in_data = 16'd2;
    tick();
    in_valid = 0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd2 || sample_cnt !== 16'd1) begin
      n_fail++; $display("FAIL rst_next got v=%b d=%h cnt=%0d want v=1 d=0002 cnt=1", out_valid, out_data, sample_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      in_data   = 16'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      n_checks++;
      if (in_ready !== (m_q.size() < 2)) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_in_ready[%0d] got %b want %b", i, in_ready, (m_q.size() < 2));
      end
      tick();
      clear = 0;
      n_checks++;
      if (out_valid !== (m_q.size() > 0) || sample_cnt !== m_cnt ||
          (m_q.size() > 0 && out_data !== m_q[0])) begin
        n_fail++; errs++;
        if (errs < 10)
          $display("FAIL rand_out[%0d] got v=%b d=%h cnt=%0d want v=%b d=%h cnt=%0d", i, out_valid, out_data,
                   sample_cnt, (m_q.size() > 0), (m_q.size() > 0) ? m_q[0] : 16'h0, m_cnt);
      end
    end
    in_valid = 0;
    out_ready = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_impulse();
    test_roundtrip();
    test_wrap();
    test_back_to_back();
    test_clear_rst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bandpass_inverse.md
BANDPASS_INVERSE -- requirements
Module: bandpass_inverse

Interface
REQ-001 Parameter: WIDTH, 16, sample width in bits for in_data and out_data.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: clear  input  1  synchronous restart of recurrence history, buffer and counter.
REQ-005 Port: in_data  input  WIDTH  signed band-pass sample y[n].
REQ-006 Port: in_valid  input  1  in_data valid this cycle.
REQ-007 Port: in_ready  output  1  block accepts a sample this cycle.
REQ-008 Port: out_data  output  WIDTH  signed reconstructed sample z[n] = x[n-1].
REQ-009 Port: out_valid  output  1  out_data valid this cycle.
REQ-010 Port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 Port: sample_cnt  output  16  number of samples accepted since reset/clear; wraps 0xFFFF->0x0000.

Function
REQ-012 Block SHALL invert the forward filter y[n] = x[n-1] - x[n-3] by the recurrence z[n] = y[n] + z[n-2], with z[-1] = z[-2] = 0 (matches the zero-initialised forward delay line).
REQ-013 History SHALL be two WIDTH-bit registers h1 (z[n-1]) and h2 (z[n-2]); on accept: z = in_data + h2, h2 <= h1, h1 <= z.
REQ-014 Addition SHALL be WIDTH-bit two's-complement modulo 2^WIDTH (wrap, no saturation), making reconstruction bit-exact for any forward-filter output stream.
REQ-015 Accept event SHALL be in_valid && in_ready at a rising clk edge; history and sample_cnt update only on accept.
REQ-016 Output SHALL be a 2-entry FIFO; in_ready = (occupancy < 2), registered-free combinational from occupancy only (no dependence on out_ready).
REQ-017 Output transfer SHALL be out_valid && out_ready; out_valid = (occupancy > 0); out_data = oldest entry.
REQ-018 Latency SHALL be 1 cycle: a sample accepted at edge k with empty FIFO appears on out_data with out_valid high after edge k.
REQ-019 Simultaneous accept and transfer SHALL leave occupancy unchanged and keep order; full throughput of one sample per cycle when out_ready held high.
REQ-020 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-021 clear SHALL, at the edge: zero h1, h2, sample_cnt, occupancy; any concurrent input sample is dropped (clear wins), any concurrent output transfer is irrelevant.
REQ-022 While clear is high, in_ready SHALL still follow REQ-016 but no state other than the reset state of REQ-021 is entered.

Reset
REQ-023 rst high SHALL immediately (asynchronously) force h1 = h2 = 0, occupancy = 0, sample_cnt = 0, out_valid = 0, out_data = 0, in_ready = 1.
REQ-024 rst asserted mid-stream SHALL discard buffered samples and history; first sample after release is treated as n = 0.
REQ-025 On rst deassertion the block SHALL accept a sample at the first rising edge with in_valid high.

Verification
REQ-026 Impulse: out_ready=1, y = 1,0,0,0,0,0 -> out_data 1,0,1,0,1,0, each 1 cycle after input; sample_cnt = 6.
REQ-027 Round-trip: x = 3,-7,100,0x7FFF,-0x8000,12 through the forward filter (delay regs zero) -> out_data equals x delayed by one sample, bit-exact.
REQ-028 Wrap: y = 0x7FFF,0,0x7FFF -> out_data 0x7FFF,0x0000,0xFFFE (no saturation).
REQ-029 Backpressure: out_ready=0, offer y = 5,5,5 back-to-back -> two accepted, in_ready low, third held; release out_ready -> outputs 5,5,10 in order, no loss or duplication.
REQ-030 clear/reset mid-stream: after y = 4,4 send clear with in_valid=1 y=9 -> sample dropped, sample_cnt=0, next y = 2 outputs 2; repeat with rst pulse between edges -> out_valid drops immediately, same post-release result.
